// File: rtl/rr_arb_4_1_if.sv
// -----------------------------------------------------------------------------
// rr_arb_4_1_if
// Stream bundle between four requesters, the round-robin arbiter and the
// downstream 4:1 mux / consumer.
//
//   in_valid[3:0]   requester valids (bit i = requester i)
//   in_data0..3     requester data, W bits each
//   in_ready[3:0]   per-requester ready from the arbiter (one-hot or zero)
//   out_valid       registered output valid
//   out_data        registered data of the granted requester
//   out_sel         registered index of the granted requester (mux select)
//   out_ready       downstream ready
//
// Modports:
//   slave  - the arbiter (consumes requests, produces the output beat)
//   master - the environment (requesters plus downstream consumer)
// -----------------------------------------------------------------------------
interface rr_arb_4_1_if #(
  parameter int W = 4
);
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
  logic [W-1:0] in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_4_1.sv
// -----------------------------------------------------------------------------
// rr_arb_4_1
// Four-input round-robin stream arbiter with a one-entry registered output.
// Each cycle the first valid requester in the order ptr, ptr+1, ptr+2, ptr+3
// (mod 4) is granted whenever the output register can accept a beat; its data
// and index are registered and the pointer moves to one past the winner.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        rr_arb_4_1_if.slave (requests in, registered beat out)
//   grant_cnt  16-bit saturating count of accepted beats
//              (present only when RR_ARB_STAT_EN is defined)
//
// Optional feature macro: RR_ARB_STAT_EN
//
// Parameter W must match the W of the connected interface instance.
// -----------------------------------------------------------------------------
module rr_arb_4_1 #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_arb_4_1_if.slave       bus
`ifdef RR_ARB_STAT_EN
  ,
  output logic [15:0]       grant_cnt
`endif
);

  // Output register occupancy; out_valid is simply state_q == FULL.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] data_q,  data_d;
  logic [1:0]   sel_q,   sel_d;
  logic [1:0]   ptr_q,   ptr_d;

  logic [1:0]   grant;
  logic         load_en;

  // Rotating priority search starting at ptr_q. Uses only in_valid, never data.
  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // The register accepts a beat when empty or when draining in the same edge.
  assign load_en = ((state_q == EMPTY) || bus.out_ready) && (|bus.in_valid);

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: load, drain, or hold.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      state_d = FULL;
      sel_d   = grant;
      ptr_d   = grant + 2'd1;   // 2-bit arithmetic wraps 3 -> 0
      case (grant)
        2'd0:    data_d = bus.in_data0;
        2'd1:    data_d = bus.in_data1;
        2'd2:    data_d = bus.in_data2;
        default: data_d = bus.in_data3;
      endcase
    end else if ((state_q == FULL) && bus.out_ready) begin
      // Drained with nothing to replace it; data/sel keep their last values.
      state_d = EMPTY;
    end
  end

  // Output logic. in_ready is gated with rst_n so no requester sees a
  // handshake while reset is asserted.
  always_comb begin
    bus.out_valid = (state_q == FULL);
    bus.out_data  = data_q;
    bus.out_sel   = sel_q;
    bus.in_ready  = (load_en && rst_n) ? (4'b0001 << grant) : 4'b0000;
  end

`ifdef RR_ARB_STAT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating beat counter: sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_4_1.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_4_1
// Self-checking bench for rr_arb_4_1. A table of per-cycle vectors carries the
// inputs and the hand-derived expected in_ready; a scoreboard queue receives
// the expected beat when a handshake is predicted and is popped when the
// output is drained. Reset-in-flight and the optional saturating counter are
// covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_rr_arb_4_1;

  logic clk;
  logic rst_n;

  rr_arb_4_1_if #(.W(4)) bus ();

`ifdef RR_ARB_STAT_EN
  logic [15:0] grant_cnt;
`endif

  rr_arb_4_1 #(.W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave)
`ifdef RR_ARB_STAT_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] sel;
  } beat_t;

  typedef struct {
    string       name;
    logic [3:0]  valid;
    logic        ready;
    logic [15:0] data;      // {d3, d2, d1, d0}
    logic [3:0]  exp_rdy;   // expected in_ready during this cycle
  } vec_t;

  vec_t   vecs[$];
  beat_t  sb[$];
  beat_t  last_beat;
  logic [15:0] exp_cnt;
  int     n_total;
  int     n_bad;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic [3:0] valid, input logic ready,
                     input logic [15:0] data, input logic [3:0] exp_rdy);
    vec_t v;
    v.name = name; v.valid = valid; v.ready = ready; v.data = data; v.exp_rdy = exp_rdy;
    vecs.push_back(v);
  endtask

  // Apply one vector; entered and left at posedge+1.
  task automatic apply(input vec_t v);
    beat_t b;
    int    idx;
    logic  drain;
    bus.in_valid  = v.valid;
    bus.out_ready = v.ready;
    bus.in_data0  = v.data[3:0];
    bus.in_data1  = v.data[7:4];
    bus.in_data2  = v.data[11:8];
    bus.in_data3  = v.data[15:12];
    #1;
    check({v.name, " in_ready"}, 32'(bus.in_ready), 32'(v.exp_rdy));
    idx = -1;
    for (int i = 0; i < 4; i++) if (v.exp_rdy[i]) idx = i;
    drain = (sb.size() != 0) && v.ready;
    @(posedge clk);
    #1;
    if (drain) void'(sb.pop_front());
    if (idx >= 0) begin
      b.sel  = 2'(idx);
      b.data = v.data[idx*4 +: 4];
      sb.push_back(b);
      last_beat = b;
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
    check({v.name, " out_valid"}, 32'(bus.out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) b = sb[0];
    else                b = last_beat;
    check({v.name, " out_data"}, 32'(bus.out_data), 32'(b.data));
    check({v.name, " out_sel"},  32'(bus.out_sel),  32'(b.sel));
`ifdef RR_ARB_STAT_EN
    check({v.name, " grant_cnt"}, 32'(grant_cnt), 32'(exp_cnt));
`endif
  endtask

  localparam logic [15:0] D_ABCD = 16'hDCBA;   // data_i = A+i
  localparam logic [15:0] D_BP   = 16'hDC5A;   // requester 2 carries 5

  initial begin
    n_total = 0;
    n_bad   = 0;
    exp_cnt = 16'd0;
    last_beat = '0;

    // Full rotation from ptr=0.
    add("rot0", 4'b1111, 1'b1, D_ABCD, 4'b0001);
    add("rot1", 4'b1111, 1'b1, D_ABCD, 4'b0010);
    add("rot2", 4'b1111, 1'b1, D_ABCD, 4'b0100);
    add("rot3", 4'b1111, 1'b1, D_ABCD, 4'b1000);
    add("rot4", 4'b1111, 1'b1, D_ABCD, 4'b0001);
    // Skip idle requesters (ptr=1 here).
    add("skip0", 4'b1010, 1'b1, D_ABCD, 4'b0010);
    add("skip1", 4'b1010, 1'b1, D_ABCD, 4'b1000);
    add("skip2", 4'b1010, 1'b1, D_ABCD, 4'b0010);
    add("skip3", 4'b1010, 1'b1, D_ABCD, 4'b1000);
    // Drain to empty, then stay idle (ptr holds at 0).
    add("drain", 4'b0000, 1'b1, D_ABCD, 4'b0000);
    add("idle",  4'b0000, 1'b1, D_ABCD, 4'b0000);
    // Backpressure: load requester 2 (ptr -> 3), stall 4 cycles, resume at 3.
    add("bp_load", 4'b0100, 1'b1, D_BP, 4'b0100);
    add("bp_st0",  4'b1111, 1'b0, D_BP, 4'b0000);
    add("bp_st1",  4'b1111, 1'b0, D_BP, 4'b0000);
    add("bp_st2",  4'b1111, 1'b0, D_BP, 4'b0000);
    add("bp_st3",  4'b1111, 1'b0, D_BP, 4'b0000);
    add("bp_go",   4'b1111, 1'b1, D_BP, 4'b1000);
    // Single requester 0: granted every cycle, ptr tracks it.
    add("one0", 4'b0001, 1'b1, D_ABCD, 4'b0001);
    add("one1", 4'b0001, 1'b1, D_ABCD, 4'b0001);
    add("one2", 4'b0001, 1'b1, D_ABCD, 4'b0001);
    // Empty register accepts even with out_ready low; then stalls.
    add("e_drain", 4'b0000, 1'b1, D_ABCD, 4'b0000);
    add("e_load",  4'b0010, 1'b0, D_ABCD, 4'b0010);
    add("e_stall", 4'b0010, 1'b0, D_ABCD, 4'b0000);
    add("e_out",   4'b0000, 1'b1, D_ABCD, 4'b0000);

    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    bus.in_data0  = '0;
    bus.in_data1  = '0;
    bus.in_data2  = '0;
    bus.in_data3  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data",  32'(bus.out_data),  32'd0);
    check("reset out_sel",   32'(bus.out_sel),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset in flight: load a beat, then assert reset mid-cycle with traffic.
    begin
      vec_t v;
      v.name = "pre_rst"; v.valid = 4'b0100; v.ready = 1'b1; v.data = D_BP; v.exp_rdy = 4'b0100;
      apply(v);   // ptr -> 3, out_valid=1 with data 5
    end
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst out_data",  32'(bus.out_data),  32'd0);
    check("mid_rst out_sel",   32'(bus.out_sel),   32'd0);
    check("mid_rst in_ready",  32'(bus.in_ready),  32'd0);
    sb.delete();
    last_beat = '0;
    exp_cnt   = 16'd0;
    bus.in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    begin
      vec_t v;
      // ptr is back at 0, so the lowest valid index (2) wins.
      v.name = "post_rst"; v.valid = 4'b1100; v.ready = 1'b1; v.data = D_ABCD; v.exp_rdy = 4'b0100;
      apply(v);
    end

`ifdef RR_ARB_STAT_EN
    // Run requester 0 back-to-back until the count reaches FFFE, then
    // three more beats must saturate at FFFF.
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b1;
    bus.in_data0  = 4'hA;
    repeat (int'(16'hFFFE - exp_cnt)) @(posedge clk);
    #1;
    exp_cnt = 16'hFFFE;
    check("cnt preload", 32'(grant_cnt), 32'hFFFE);
    sb.delete();
    last_beat.data = 4'hA;
    last_beat.sel  = 2'd0;
    sb.push_back(last_beat);
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v.name = "sat"; v.valid = 4'b0001; v.ready = 1'b1; v.data = D_ABCD; v.exp_rdy = 4'b0001;
      apply(v);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
